// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the program counter, steps or branches it
// while a program runs, and counts executed (non-stalled) cycles.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             Ack,
    input  logic             BranchEn,
    input  logic             OffsetSrc,
    input  logic [PC_W-1:0]  LutOffset,
    input  logic [7:0]       RegOffset,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             InstrValid,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic signed [PC_W-1:0] offset;

    function automatic logic signed [PC_W-1:0] sext_reg(input logic [7:0] v);
        return PC_W'($signed(v));
    endfunction

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        offset = OffsetSrc ? sext_reg(RegOffset) : $signed(LutOffset);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (Start) begin
            state_d = RUN;
            pc_d    = StartAddr;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!Stall) begin
                        cnt_d = sat_inc(cnt_q);
                        if (Ack) begin
                            // PC stays on the halting instruction.
                            state_d = HALT;
                        end else if (BranchEn) begin
                            pc_d = pc_q + offset;
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                end
                IDLE, HALT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ProgCtr    = pc_q;
    assign CycleCount = cnt_q;
    assign InstrValid = (state_q == RUN);
    assign Done       = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all checked
// against an integer-level model of the fetch rules.
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int CNT_W   = 6;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic             Stall;
    logic             Ack;
    logic             BranchEn;
    logic             OffsetSrc;
    logic [PC_W-1:0]  LutOffset;
    logic [7:0]       RegOffset;
    logic [PC_W-1:0]  ProgCtr;
    logic             InstrValid;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = idle, 1 = running, 2 = halted.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .Ack        (Ack),
        .BranchEn   (BranchEn),
        .OffsetSrc  (OffsetSrc),
        .LutOffset  (LutOffset),
        .RegOffset  (RegOffset),
        .ProgCtr    (ProgCtr),
        .InstrValid (InstrValid),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int signed_of(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, compare outputs.
    task automatic step(input bit rst, input bit st, input int addr, input bit stl,
                        input bit ak, input bit br, input bit src, input int lut,
                        input int rg);
        int off;
        Reset     = rst;
        Start     = st;
        StartAddr = PC_W'(addr);
        Stall     = stl;
        Ack       = ak;
        BranchEn  = br;
        OffsetSrc = src;
        LutOffset = PC_W'(lut);
        RegOffset = 8'(rg);
        @(posedge Clk);
        if (rst) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
        end else if (st) begin
            m_mode = 1; m_pc = addr % PC_MOD; m_cnt = 0;
        end else if (m_mode == 1 && !stl) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (ak) begin
                m_mode = 2;
            end else if (br) begin
                off  = src ? signed_of(rg & 255, 8) : signed_of(lut % PC_MOD, PC_W);
                m_pc = (((m_pc + off) % PC_MOD) + PC_MOD) % PC_MOD;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
        #1;
        check_val("ProgCtr",    ProgCtr,    m_pc);
        check_val("InstrValid", InstrValid, (m_mode == 1) ? 1 : 0);
        check_val("Done",       Done,       (m_mode == 2) ? 1 : 0);
        check_val("CycleCount", CycleCount, m_cnt);
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic start_at(input int addr);
        step(0, 1, addr, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cnt_hold;
        Reset = 1'b0; Start = 1'b0; StartAddr = '0; Stall = 1'b0; Ack = 1'b0;
        BranchEn = 1'b0; OffsetSrc = 1'b0; LutOffset = '0; RegOffset = '0;
        @(posedge Clk);
        #1;

        // Reset state, then idle must ignore everything except Start.
        step(1, 0, 0, 0, 1, 1, 0, 3, 0);
        check_val("rst_pc", ProgCtr, 0);
        check_val("rst_valid", InstrValid, 0);
        step(0, 0, 0, 1, 1, 1, 1, 9, 9);
        step(0, 0, 0, 0, 0, 1, 0, 9, 0);
        check_val("idle_hold_pc", ProgCtr, 0);

        // Sequential fetch from 5.
        start_at(5);
        check_val("start_pc", ProgCtr, 5);
        check_val("start_valid", InstrValid, 1);
        repeat (3) idle_cycle();
        check_val("seq_pc", ProgCtr, 8);
        check_val("seq_cnt", CycleCount, 3);

        // LUT branch backwards, then register branch forwards.
        start_at(20);
        step(0, 0, 0, 0, 0, 1, 0, 10'h3FC, 0);
        check_val("lut_branch", ProgCtr, 16);
        step(0, 0, 0, 0, 0, 1, 1, 0, 8'h7F);
        check_val("reg_branch", ProgCtr, 143);

        // Wrap-around both directions, and a zero offset self-loop.
        start_at(1023);
        idle_cycle();
        check_val("wrap_fwd", ProgCtr, 0);
        start_at(2);
        step(0, 0, 0, 0, 0, 1, 1, 0, 8'hF0);
        check_val("wrap_back", ProgCtr, 1010);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_val("self_loop", ProgCtr, 1010);

        // Ack beats BranchEn; halted state then frozen.
        start_at(40);
        step(0, 0, 0, 0, 1, 1, 0, 5, 0);
        check_val("halt_done", Done, 1);
        check_val("halt_pc", ProgCtr, 40);
        check_val("halt_valid", InstrValid, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, i % 2, 0, i % 2, 0, 7, 0);
        check_val("halt_freeze_pc", ProgCtr, 40);
        check_val("halt_freeze_cnt", CycleCount, 1);

        // Stall overrides Ack for 4 cycles.
        start_at(50);
        idle_cycle();
        cnt_hold = int'(CycleCount);
        repeat (4) step(0, 0, 0, 1, 1, 1, 0, 3, 0);
        check_val("stall_pc", ProgCtr, 51);
        check_val("stall_cnt", CycleCount, cnt_hold);
        check_val("stall_valid", InstrValid, 1);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        check_val("stall_release_done", Done, 1);
        check_val("stall_release_cnt", CycleCount, cnt_hold + 1);

        // Reset beats Start in mid-run; later restart from HALT.
        start_at(300);
        step(1, 1, 123, 0, 0, 0, 0, 0, 0);
        check_val("rst_start_pc", ProgCtr, 0);
        check_val("rst_start_valid", InstrValid, 0);
        check_val("rst_start_cnt", CycleCount, 0);
        start_at(9);
        idle_cycle();
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        start_at(7);
        check_val("restart_pc", ProgCtr, 7);
        check_val("restart_cnt", CycleCount, 0);
        check_val("restart_valid", InstrValid, 1);

        // Counter saturation.
        repeat (CNT_MAX + 5) idle_cycle();
        check_val("cnt_saturate", CycleCount, CNT_MAX);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(99, 0) < 1,
                 $urandom_range(99, 0) < 3,
                 int'($urandom_range(PC_MOD - 1, 0)),
                 $urandom_range(99, 0) < 25,
                 $urandom_range(99, 0) < 4,
                 $urandom_range(99, 0) < 30,
                 $urandom_range(1, 0),
                 int'($urandom_range(PC_MOD - 1, 0)),
                 int'($urandom_range(255, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning the program counter width (1024-entry instruction space).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the executed-cycle counter.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port Start, input, 1 bit: a one-cycle request to begin a program at StartAddr.
REQ-006 The block SHALL have port StartAddr, input, PC_W bits: the program entry address.
REQ-007 The block SHALL have port Stall, input, 1 bit: hold PC and the counter this cycle.
REQ-008 The block SHALL have port Ack, input, 1 bit: "done w/ program" from the decoder; asserted for instruction 9'h1FF.
REQ-009 The block SHALL have port BranchEn, input, 1 bit: the current instruction is a branch and its condition is met.
REQ-010 The block SHALL have port OffsetSrc, input, 1 bit: select the branch offset, 1 = RegOffset, 0 = LutOffset.
REQ-011 The block SHALL have port LutOffset, input, PC_W bits: signed two's-complement offset from the branch LUT.
REQ-012 The block SHALL have port RegOffset, input, 8 bits: signed two's-complement offset from the register file.
REQ-013 The block SHALL have port ProgCtr, output, PC_W bits: the instruction ROM address.
REQ-014 The block SHALL have port InstrValid, output, 1 bit: ProgCtr addresses an instruction that is executing this cycle.
REQ-015 The block SHALL have port Done, output, 1 bit: the program has halted.
REQ-016 The block SHALL have port CycleCount, output, CNT_W bits: the number of executed (non-stalled RUN) cycles since the last Start.

Function
REQ-017 The block SHALL implement a state machine with states IDLE, RUN and HALT.
REQ-018 Outputs SHALL be decoded from state only: InstrValid = (state==RUN), Done = (state==HALT).
REQ-019 In IDLE or HALT with Start=1, the block SHALL load ProgCtr<=StartAddr, clear CycleCount to 0 and enter RUN at the next edge.
REQ-020 In RUN with Start=1, the block SHALL restart identically to REQ-019, reloading StartAddr, clearing the counter and remaining in RUN.
REQ-021 In RUN with Start=0 and Stall=1, ProgCtr, CycleCount and state SHALL hold, and Ack and BranchEn SHALL be ignored.
REQ-022 In RUN with Start=0, Stall=0 and Ack=1, the block SHALL enter HALT, hold ProgCtr at the Ack instruction address and increment CycleCount.
REQ-023 In RUN with Start=0, Stall=0, Ack=0 and BranchEn=1, the block SHALL set ProgCtr <= ProgCtr + offset and increment CycleCount.
REQ-024 The offset SHALL be LutOffset when OffsetSrc=0, or RegOffset sign-extended to PC_W when OffsetSrc=1.
REQ-025 In RUN with Start=0, Stall=0, Ack=0 and BranchEn=0, the block SHALL set ProgCtr <= ProgCtr + 1 and increment CycleCount.
REQ-026 ProgCtr arithmetic SHALL be modulo 2^PC_W, so forward and backward wrap-around is silent.
REQ-027 A branch offset of 0 SHALL self-loop at the same address.
REQ-028 Event priority SHALL be: Reset > Start > Stall > Ack > BranchEn > increment.
REQ-029 Ack SHALL take priority over BranchEn when both are asserted.
REQ-030 CycleCount SHALL saturate at all-ones and never wrap.
REQ-031 CycleCount SHALL freeze in HALT and IDLE.
REQ-032 In IDLE or HALT with Start=0, ProgCtr SHALL hold its value regardless of Stall, Ack and BranchEn.
REQ-033 There SHALL be no combinational path from any input to any output; the latency from Start to the first InstrValid is 1 cycle.

Reset
REQ-034 Reset=1 at a rising edge SHALL force state=IDLE, ProgCtr=0 and CycleCount=0, so that InstrValid=0 and Done=0, regardless of all other inputs, including in the middle of RUN or when asserted together with Start.
REQ-035 After Reset deasserts, the block SHALL remain in IDLE until a Start.

Verification
REQ-036 The bench SHALL cover: Reset, then Start with StartAddr=10'd5 for 1 cycle, then Ack=0 and BranchEn=0 for 3 cycles -> ProgCtr 5,6,7,8 with InstrValid=1 and CycleCount=3.
REQ-037 The bench SHALL cover: in RUN at ProgCtr=20, BranchEn=1 with OffsetSrc=0 and LutOffset=-4 (10'h3FC) -> ProgCtr=16; then OffsetSrc=1 with RegOffset=8'h7F -> ProgCtr=143.
REQ-038 The bench SHALL cover: ProgCtr=1023 with no branch -> 0; ProgCtr=2 with RegOffset=8'hF0 (-16) -> 1010.
REQ-039 The bench SHALL cover: in RUN at ProgCtr=40, Ack=1 and BranchEn=1 together -> next cycle state HALT, Done=1, ProgCtr=40, InstrValid=0; ProgCtr and CycleCount then stay constant for 10 further cycles with BranchEn toggling.
REQ-040 The bench SHALL cover: Stall=1 for 4 cycles in RUN with Ack=1 -> ProgCtr, CycleCount and state unchanged; after Stall drops, HALT on the next edge.
REQ-041 The bench SHALL cover: Reset asserted in RUN at ProgCtr=300 together with Start=1 -> IDLE, ProgCtr=0, CycleCount=0; a later Start from HALT with StartAddr=7 -> RUN at 7 with CycleCount cleared.
